// File: rtl/controlador_multiplicacao_if.sv
// Handshake and core-facing signal bundle for the multiplier sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic
// (operand source, result sink and the multiplier core).
interface controlador_multiplicacao_if #(
  parameter int unsigned WIDTH = 8
);
  // Operand channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  // Multiplier core side
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_clear;
  logic             mult_start;
  logic [WIDTH-1:0] mult_produto;
  logic             mult_overflow;
  logic             mult_done;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_produto;
  logic             out_overflow;
  logic             out_error;

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready,
    output mult_a, mult_b, mult_clear, mult_start,
    input  mult_produto, mult_overflow, mult_done,
    output out_valid, out_produto, out_overflow, out_error,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mult_a, mult_b, mult_clear, mult_start,
    output mult_produto, mult_overflow, mult_done,
    input  out_valid, out_produto, out_overflow, out_error,
    output out_ready
  );
endinterface

// File: rtl/controlador_multiplicacao.sv
// Sequencer in front of the 8-bit shift-add multiplier core: accepts one operand
// pair, loads and runs the core, captures its result and hands it downstream.
// Zero operands skip the core entirely; a watchdog turns a hung core into an
// error result.
module controlador_multiplicacao #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                         clk,
  input logic                         rst,
  controlador_multiplicacao_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StHold
  } state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  // State, operand, watchdog and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state, operand capture, watchdog and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d    = bus.in_a;
          b_d    = bus.in_b;
          // Clear the result now so the zero path hands out a clean 0
          prod_d = '0;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
          if ((bus.in_a == '0) || (bus.in_b == '0)) begin
            state_d = StHold;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        // done is checked before the watchdog so a last-cycle done is not an error
        if (bus.mult_done) begin
          prod_d  = bus.mult_produto;
          ovf_d   = bus.mult_overflow;
          err_d   = 1'b0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutVal) begin
            prod_d  = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the state register
  assign bus.in_ready     = (state_q == StIdle);
  assign bus.mult_clear   = (state_q == StLoad);
  assign bus.mult_start   = (state_q == StRun);
  assign bus.out_valid    = (state_q == StHold);
  assign bus.mult_a       = a_q;
  assign bus.mult_b       = b_q;
  assign bus.out_produto  = prod_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_error    = err_q;

endmodule

// File: tb/tb_controlador_multiplicacao.sv
// Directed bench for controlador_multiplicacao with a simple saturating core model.
module tb_controlador_multiplicacao;

  logic clk;
  logic rst;

  controlador_multiplicacao_if #(.WIDTH(8)) bus ();

  controlador_multiplicacao #(
    .WIDTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  // Core model: done after core_lat RUN cycles, saturating 8-bit product
  logic        core_en;
  logic [7:0]  core_lat;
  logic [7:0]  run_cnt;
  logic [15:0] prod16;

  always @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= '0;
    else if (bus.mult_clear) run_cnt <= '0;
    else if (bus.mult_start) run_cnt <= run_cnt + 8'd1;
  end

  assign prod16            = bus.mult_a * bus.mult_b;
  assign bus.mult_produto  = (prod16 > 16'd255) ? 8'hFF : prod16[7:0];
  assign bus.mult_overflow = (prod16 > 16'd255);
  assign bus.mult_done     = core_en && bus.mult_start && (run_cnt == core_lat - 8'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a pair, waits for acceptance and then for out_valid.
  // lat counts cycles from the accepting edge; clr/st count strobe cycles.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int clr, output int st);
    int w;
    @(negedge clk);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    clr = 0;
    st  = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.mult_clear) clr++;
      if (bus.mult_start) st++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mult_clear !== 1'b0 ||
        bus.mult_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b clear=%b start=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.mult_clear, bus.mult_start);
    end
    checks++;
    if (bus.mult_a !== 8'd0 || bus.mult_b !== 8'd0 || bus.out_produto !== 8'd0 ||
        bus.out_overflow !== 1'b0 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: a=%0d b=%0d p=%0d o=%b e=%b want all 0",
               bus.mult_a, bus.mult_b, bus.out_produto, bus.out_overflow, bus.out_error);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int lat, clr, st;
    core_en  = 1'b1;
    core_lat = 8'd9;
    do_op(8'd5, 8'd6, lat, clr, st);
    checks++;
    if (lat !== 11 || clr !== 1 || st !== 9) begin
      errors++;
      $display("FAIL normal_timing: lat=%0d clr=%0d st=%0d want 11 1 9", lat, clr, st);
    end
    checks++;
    if (bus.out_produto !== 8'd30 || bus.out_overflow !== 1'b0 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL normal_result: p=%0d o=%b e=%b want 30 0 0",
               bus.out_produto, bus.out_overflow, bus.out_error);
    end
    checks++;
    if (bus.mult_a !== 8'd5 || bus.mult_b !== 8'd6 || bus.mult_start !== 1'b0) begin
      errors++;
      $display("FAIL normal_operands: a=%0d b=%0d start=%b want 5 6 0",
               bus.mult_a, bus.mult_b, bus.mult_start);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL normal_release: out_valid=%b in_ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_zero();
    int lat, clr, st;
    do_op(8'd0, 8'd200, lat, clr, st);
    checks++;
    if (lat !== 1 || clr !== 0 || st !== 0) begin
      errors++;
      $display("FAIL zero_timing: lat=%0d clr=%0d st=%0d want 1 0 0", lat, clr, st);
    end
    checks++;
    if (bus.out_produto !== 8'd0 || bus.out_overflow !== 1'b0 || bus.out_error !== 1'b0 ||
        bus.mult_start !== 1'b0 || bus.mult_clear !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: p=%0d o=%b e=%b start=%b clr=%b want 0 0 0 0 0",
               bus.out_produto, bus.out_overflow, bus.out_error, bus.mult_start,
               bus.mult_clear);
    end
    release_result();
  endtask

  task automatic test_timeout();
    int lat, clr, st;
    core_en = 1'b0;
    do_op(8'd3, 8'd7, lat, clr, st);
    checks++;
    if (lat !== 18 || clr !== 1 || st !== 16) begin
      errors++;
      $display("FAIL timeout_timing: lat=%0d clr=%0d st=%0d want 18 1 16", lat, clr, st);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_error !== 1'b1 || bus.out_produto !== 8'd0 ||
        bus.out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: v=%b e=%b p=%0d o=%b want 1 1 0 0",
               bus.out_valid, bus.out_error, bus.out_produto, bus.out_overflow);
    end
    release_result();
    core_en = 1'b1;
  endtask

  task automatic test_done_at_timeout();
    int lat, clr, st;
    core_lat = 8'd16;
    do_op(8'd2, 8'd9, lat, clr, st);
    checks++;
    if (lat !== 18 || st !== 16 || bus.out_error !== 1'b0 || bus.out_produto !== 8'd18) begin
      errors++;
      $display("FAIL done_wins: lat=%0d st=%0d e=%b p=%0d want 18 16 0 18",
               lat, st, bus.out_error, bus.out_produto);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat, clr, st;
    core_lat = 8'd4;
    do_op(8'd20, 8'd20, lat, clr, st);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL bp_latency: lat=%0d want 6", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_produto !== 8'd255 || bus.out_overflow !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable[%0d]: v=%b p=%0d o=%b rdy=%b want 1 255 1 0",
                 i, bus.out_valid, bus.out_produto, bus.out_overflow, bus.in_ready);
      end
      @(negedge clk);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, clr, st;
    core_lat = 8'd9;
    @(negedge clk);
    bus.in_a = 8'd9;
    bus.in_b = 8'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mult_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_run: start=%b want 1", bus.mult_start);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mult_start !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.mult_a !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: rdy=%b start=%b v=%b a=%0d want 1 0 0 0",
               bus.in_ready, bus.mult_start, bus.out_valid, bus.mult_a);
    end
    @(negedge clk);
    rst = 1'b0;
    core_lat = 8'd2;
    do_op(8'd2, 8'd3, lat, clr, st);
    checks++;
    if (lat !== 4 || bus.out_produto !== 8'd6 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_op: lat=%0d p=%0d e=%b want 4 6 0",
               lat, bus.out_produto, bus.out_error);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [7:0] pe [4];
    int pi, ri;
    logic acc;
    pa[0] = 8'd3; pb[0] = 8'd4; pe[0] = 8'd12;
    pa[1] = 8'd0; pb[1] = 8'd9; pe[1] = 8'd0;
    pa[2] = 8'd7; pb[2] = 8'd1; pe[2] = 8'd7;
    pa[3] = 8'd2; pb[3] = 8'd5; pe[3] = 8'd10;
    core_lat = 8'd2;
    pi = 0;
    ri = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_a = pa[0];
    bus.in_b = pb[0];
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && ri < 4; cyc++) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.out_produto !== pe[ri]) begin
          errors++;
          $display("FAIL b2b_result[%0d]: p=%0d want %0d", ri, bus.out_produto, pe[ri]);
        end
        ri++;
      end
      if (bus.mult_clear && pi > 0) begin
        checks++;
        if (bus.mult_a !== pa[pi-1] || bus.mult_b !== pb[pi-1]) begin
          errors++;
          $display("FAIL b2b_operands[%0d]: a=%0d b=%0d want %0d %0d",
                   pi - 1, bus.mult_a, bus.mult_b, pa[pi-1], pb[pi-1]);
        end
      end
      acc = bus.in_ready && bus.in_valid;
      @(negedge clk);
      if (acc) begin
        pi++;
        if (pi < 4) begin
          bus.in_a = pa[pi];
          bus.in_b = pb[pi];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (pi !== 4 || ri !== 4) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d results=%0d want 4 4", pi, ri);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    core_en       = 1'b1;
    core_lat      = 8'd9;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_zero();
    test_timeout();
    test_done_at_timeout();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
